// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus controller.
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;
    localparam logic [MEM_ADDR_W-1:0] MEM_LAST_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        ERR
    } mem_bus_state_t;

    // Read-modify-write merge: keep the high byte read back, replace the low byte.
    function automatic logic [MEM_DATA_W-1:0] merge_low_byte(
        input logic [7:0] i_hi,
        input logic [7:0] i_lo
    );
        return {i_hi, i_lo};
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/response handshake and memory-side signals of the bus controller.
interface mem_bus_ctrl_if;
    import mem_bus_pkg::*;

    logic                  reqValid;
    logic                  reqReady;
    logic [MEM_ADDR_W-1:0] reqAddr;
    logic                  reqWrite;
    logic                  reqByte;
    logic [MEM_DATA_W-1:0] reqWData;
    logic                  rspValid;
    logic [MEM_DATA_W-1:0] rspData;
    logic                  rspErr;
    logic [MEM_ADDR_W-1:0] memAddr;
    logic                  memRe;
    logic                  memWe;
    logic [MEM_DATA_W-1:0] memWBus;
    logic [MEM_DATA_W-1:0] memRBus;

    // Controller side.
    modport slave (
        input  reqValid, reqAddr, reqWrite, reqByte, reqWData, memRBus,
        output reqReady, rspValid, rspData, rspErr,
               memAddr, memRe, memWe, memWBus
    );

    // Requester and memory side.
    modport master (
        output reqValid, reqAddr, reqWrite, reqByte, reqWData, memRBus,
        input  reqReady, rspValid, rspData, rspErr,
               memAddr, memRe, memWe, memWBus
    );

endinterface

// File: rtl/mem_bus_ctrl.sv
// Bus controller: sequences one load/store at a time onto a byte-addressed
// 16-bit memory, with read-modify-write for byte stores and a registered,
// glitch-free write strobe of STROBE_CYCLES cycles.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int STROBE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rstN,
    mem_bus_ctrl_if.slave  bus
);

    mem_bus_state_t        r_state;
    mem_bus_state_t        w_next;
    logic [1:0]            r_cnt;
    logic                  r_byte;
    logic [7:0]            r_wdataLo;
    logic [MEM_ADDR_W-1:0] r_memAddr;
    logic [MEM_DATA_W-1:0] r_memWBus;
    logic                  r_memRe;
    logic                  r_memWe;
    logic                  r_rspValid;
    logic                  r_rspErr;
    logic [MEM_DATA_W-1:0] r_rspData;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_badAddr;

    assign w_ready   = (r_state == IDLE) && rstN;
    assign w_accept  = bus.reqValid && w_ready;
    // The top address is only reachable by a byte load; anything else would touch addr+1.
    assign w_badAddr = (bus.reqAddr == MEM_LAST_ADDR) && !(bus.reqByte && !bus.reqWrite);

    // Next-state decode for the access sequence.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_badAddr)          w_next = ERR;
                    else if (!bus.reqWrite) w_next = RD;
                    else if (bus.reqByte)   w_next = RMW_RD;
                    else                    w_next = WR_SETUP;
                end
            end
            RD:        w_next = IDLE;
            RMW_RD:    w_next = WR_SETUP;
            WR_SETUP:  w_next = WR_STROBE;
            WR_STROBE: w_next = (r_cnt == 2'd0) ? WR_HOLD : WR_STROBE;
            WR_HOLD:   w_next = IDLE;
            ERR:       w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // State, registered memory strobes, address/data latches and response pulse.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_byte     <= 1'b0;
            r_wdataLo  <= 8'h00;
            r_memAddr  <= '0;
            r_memWBus  <= '0;
            r_memRe    <= 1'b0;
            r_memWe    <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspData  <= '0;
        end else begin
            r_state <= w_next;
            // Enables are decoded from the next state so they are flop outputs aligned with the state.
            r_memRe <= (w_next == RD) || (w_next == RMW_RD);
            r_memWe <= (w_next == WR_STROBE);

            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspData  <= '0;

            if (w_accept) begin
                r_byte    <= bus.reqByte;
                r_wdataLo <= bus.reqWData[7:0];
                if (!w_badAddr) begin
                    r_memAddr <= bus.reqAddr;
                end
                if (bus.reqWrite && !bus.reqByte && !w_badAddr) begin
                    r_memWBus <= bus.reqWData;
                end
            end

            case (r_state)
                RD: begin
                    r_rspValid <= 1'b1;
                    r_rspData  <= r_byte ? {8'h00, bus.memRBus[7:0]} : bus.memRBus;
                end
                RMW_RD: begin
                    r_memWBus <= merge_low_byte(bus.memRBus[15:8], r_wdataLo);
                end
                WR_SETUP: begin
                    r_cnt <= 2'(STROBE_CYCLES - 1);
                end
                WR_STROBE: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                WR_HOLD: begin
                    r_rspValid <= 1'b1;
                end
                ERR: begin
                    r_rspValid <= 1'b1;
                    r_rspErr   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.reqReady = w_ready;
    assign bus.rspValid = r_rspValid;
    assign bus.rspErr   = r_rspErr;
    assign bus.rspData  = r_rspData;
    assign bus.memAddr  = r_memAddr;
    assign bus.memRe    = r_memRe;
    assign bus.memWe    = r_memWe;
    assign bus.memWBus  = r_memWBus;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench: two controllers (strobe width 1 and 3), each with its own
// byte-array memory that writes on the rising edge of memWe.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        sel = 1'b0;
    logic        reqValid = 1'b0;
    logic [15:0] reqAddr = 16'h0;
    logic        reqWrite = 1'b0;
    logic        reqByte = 1'b0;
    logic [15:0] reqWData = 16'h0;

    int passed = 0;
    int total  = 0;

    logic [15:0] we_mask, re_mask, ready_mask, both_mask;
    int          rsp_cyc, rsp_count;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        got_ready;

    logic [7:0] memA [0:65535];
    logic [7:0] memB [0:65535];

    mem_bus_ctrl_if busA();
    mem_bus_ctrl_if busB();

    mem_bus_ctrl #(.STROBE_CYCLES(1)) dutA (.clk(clk), .rstN(rstN), .bus(busA.slave));
    mem_bus_ctrl #(.STROBE_CYCLES(3)) dutB (.clk(clk), .rstN(rstN), .bus(busB.slave));

    always #5 clk = ~clk;

    assign busA.reqValid = reqValid && !sel;
    assign busA.reqAddr  = reqAddr;
    assign busA.reqWrite = reqWrite;
    assign busA.reqByte  = reqByte;
    assign busA.reqWData = reqWData;
    assign busB.reqValid = reqValid && sel;
    assign busB.reqAddr  = reqAddr;
    assign busB.reqWrite = reqWrite;
    assign busB.reqByte  = reqByte;
    assign busB.reqWData = reqWData;

    assign busA.memRBus = busA.memRe ? {memA[busA.memAddr + 16'd1], memA[busA.memAddr]} : 16'hzzzz;
    assign busB.memRBus = busB.memRe ? {memB[busB.memAddr + 16'd1], memB[busB.memAddr]} : 16'hzzzz;

    always @(posedge busA.memWe) begin
        memA[busA.memAddr]         <= busA.memWBus[7:0];
        memA[busA.memAddr + 16'd1] <= busA.memWBus[15:8];
    end

    always @(posedge busB.memWe) begin
        memB[busB.memAddr]         <= busB.memWBus[7:0];
        memB[busB.memAddr + 16'd1] <= busB.memWBus[15:8];
    end

    wire        s_ready = sel ? busB.reqReady : busA.reqReady;
    wire        s_we    = sel ? busB.memWe    : busA.memWe;
    wire        s_re    = sel ? busB.memRe    : busA.memRe;
    wire        s_rspV  = sel ? busB.rspValid : busA.rspValid;
    wire        s_rspE  = sel ? busB.rspErr   : busA.rspErr;
    wire [15:0] s_rspD  = sel ? busB.rspData  : busA.rspData;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request at a negedge, accept on the next ready edge (edge 0),
    // then record cycles 1..ncyc at each negedge. rst_cyc>0 pulls rstN low
    // during that cycle for one edge.
    task automatic run_req(input logic s, input logic [15:0] a, input logic w, input logic b,
                           input logic [15:0] d, input int ncyc, input int rst_cyc);
        sel = s; reqAddr = a; reqWrite = w; reqByte = b; reqWData = d; reqValid = 1'b1;
        got_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (s_ready) begin
                got_ready = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_timeout", {15'd0, got_ready}, 16'd1);
        @(posedge clk);
        #1 reqValid = 1'b0;
        we_mask = 0; re_mask = 0; ready_mask = 0; both_mask = 0;
        rsp_cyc = 0; rsp_count = 0; rsp_data = 16'h0; rsp_err = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            we_mask[c]    = s_we;
            re_mask[c]    = s_re;
            ready_mask[c] = s_ready;
            both_mask[c]  = s_we && s_re;
            if (s_rspV) begin
                rsp_count++;
                if (rsp_cyc == 0) begin
                    rsp_cyc = c; rsp_data = s_rspD; rsp_err = s_rspE;
                end
            end
            if (rst_cyc != 0 && c == rst_cyc)     rstN = 1'b0;
            if (rst_cyc != 0 && c == rst_cyc + 1) rstN = 1'b1;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  {15'd0, busA.reqReady}, 16'd0);
        chk({tag, "_rspv"},   {15'd0, busA.rspValid}, 16'd0);
        chk({tag, "_rspd"},   busA.rspData, 16'h0);
        chk({tag, "_rspe"},   {15'd0, busA.rspErr}, 16'd0);
        chk({tag, "_addr"},   busA.memAddr, 16'h0);
        chk({tag, "_re"},     {15'd0, busA.memRe}, 16'd0);
        chk({tag, "_we"},     {15'd0, busA.memWe}, 16'd0);
        chk({tag, "_wbus"},   busA.memWBus, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            memA[i] = 8'h00;
            memB[i] = 8'h00;
        end
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("init");
        rstN = 1'b1;
        @(negedge clk);

        // Word store then load.
        run_req(1'b0, 16'h0100, 1'b1, 1'b0, 16'h1234, 8, 0);
        chk("wst_we_mask", we_mask, 16'h0004);
        chk("wst_rsp_cyc", 16'(rsp_cyc), 16'd4);
        chk("wst_rsp_err", {15'd0, rsp_err}, 16'd0);
        chk("wst_rsp_cnt", 16'(rsp_count), 16'd1);
        run_req(1'b0, 16'h0100, 1'b0, 1'b0, 16'h0000, 6, 0);
        chk("wld_rsp_cyc", 16'(rsp_cyc), 16'd2);
        chk("wld_data", rsp_data, 16'h1234);
        chk("wld_err", {15'd0, rsp_err}, 16'd0);
        chk("wld_re_mask", re_mask, 16'h0002);
        chk("wld_ready_c2", {15'd0, ready_mask[2]}, 16'd1);

        // Reset for two cycles while idle; memAddr was 0x0100.
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("idle_rst");
        rstN = 1'b1;
        @(negedge clk);
        chk("rel_ready", {15'd0, busA.reqReady}, 16'd1);

        // Byte store over existing word.
        run_req(1'b0, 16'h0101, 1'b1, 1'b0, 16'h5678, 8, 0);
        run_req(1'b0, 16'h0101, 1'b1, 1'b1, 16'hCDAB, 10, 0);
        chk("bst_rsp_cyc", 16'(rsp_cyc), 16'd5);
        chk("bst_we_mask", we_mask, 16'h0008);
        chk("bst_re_mask", re_mask, 16'h0002);
        chk("bst_no_overlap", both_mask, 16'h0000);
        run_req(1'b0, 16'h0101, 1'b0, 1'b0, 16'h0000, 4, 0);
        chk("bst_wld", rsp_data, 16'h56AB);
        run_req(1'b0, 16'h0101, 1'b0, 1'b1, 16'h0000, 4, 0);
        chk("bst_bld", rsp_data, 16'h00AB);
        run_req(1'b0, 16'h0100, 1'b0, 1'b0, 16'h0000, 4, 0);
        chk("bst_wld_lo", rsp_data, 16'hAB34);

        // Boundary address.
        run_req(1'b0, 16'hFFFE, 1'b1, 1'b0, 16'h9A77, 8, 0);
        run_req(1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 6, 0);
        chk("wld_ffff_cyc", 16'(rsp_cyc), 16'd2);
        chk("wld_ffff_err", {15'd0, rsp_err}, 16'd1);
        chk("wld_ffff_data", rsp_data, 16'h0000);
        chk("wld_ffff_re", re_mask, 16'h0000);
        chk("wld_ffff_we", we_mask, 16'h0000);
        run_req(1'b0, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 4, 0);
        chk("bld_ffff_err", {15'd0, rsp_err}, 16'd0);
        chk("bld_ffff_data", rsp_data, 16'h009A);
        chk("bld_ffff_cyc", 16'(rsp_cyc), 16'd2);
        run_req(1'b0, 16'hFFFF, 1'b1, 1'b1, 16'h0011, 6, 0);
        chk("bst_ffff_err", {15'd0, rsp_err}, 16'd1);
        chk("bst_ffff_cyc", 16'(rsp_cyc), 16'd2);
        chk("bst_ffff_we", we_mask | re_mask, 16'h0000);
        run_req(1'b0, 16'hFFFF, 1'b1, 1'b0, 16'h2222, 6, 0);
        chk("wst_ffff_err", {15'd0, rsp_err}, 16'd1);

        // Three-cycle strobe on the second controller.
        run_req(1'b1, 16'h0200, 1'b1, 1'b0, 16'hBEEF, 9, 0);
        chk("s3_we_mask", we_mask, 16'h001C);
        chk("s3_rsp_cyc", 16'(rsp_cyc), 16'd6);
        chk("s3_busy", ready_mask & 16'h003E, 16'h0000);
        chk("s3_ready_c6", {15'd0, ready_mask[6]}, 16'd1);
        run_req(1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 4, 0);
        chk("s3_wld", rsp_data, 16'hBEEF);

        // Reset during the first strobe cycle: write stands, no response.
        run_req(1'b0, 16'h0300, 1'b1, 1'b0, 16'h1111, 8, 2);
        chk("rst_we_mask", we_mask, 16'h0004);
        chk("rst_no_rsp", 16'(rsp_count), 16'd0);
        run_req(1'b0, 16'h0302, 1'b1, 1'b0, 16'h2222, 8, 0);
        chk("post_rst_cyc", 16'(rsp_cyc), 16'd4);
        chk("post_rst_we", we_mask, 16'h0004);
        run_req(1'b0, 16'h0300, 1'b0, 1'b0, 16'h0000, 4, 0);
        chk("rst_write_stands", rsp_data, 16'h1111);
        run_req(1'b0, 16'h0302, 1'b0, 1'b0, 16'h0000, 4, 0);
        chk("post_rst_data", rsp_data, 16'h2222);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
